apple_bus_sampler: RTL
======================

Name: apple_bus_sampler

Overview:
Parametrised Apple II bus sampler that replaces fixed-timing bus capture with runtime-programmable sample points. It synchronises Phi1, counts clocks within each phase, and latches address/RW at a programmed count. Data is sampled at several taps, and a bitwise majority vote rejects glitches. Each completed bus cycle is pushed into a show-ahead FIFO for downstream consumers such as the card emulators and debug capture.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
CNT_W, 6, phase counter width; the counter saturates at 2^CNT_W-1
ADDR_COUNT, 18, reset/default value used when cfg_load_i has never been asserted
DATA_COUNT, 15, default first data tap count
DATA_TAPS, 3, number of data samples; must be odd and ≥1 (1 means no vote)
TAP_SPACING, 1, clocks between taps; must be ≥1
FIFO_DEPTH, 8, number of cycle records; power of 2 and ≥2
SYNC_STAGES, 2, phi1 synchroniser depth; must be ≥2

Ports:
clk_logic_i  in  1  logic clock; the only clock
system_reset_n_i  in  1  asynchronous, active-low reset
phi1_i  in  1  raw Apple II Phi1
a2_a_i  in  ADDR_W  raw address bus
a2_d_i  in  DATA_W  raw data bus
a2_rw_n_i  in  1  raw R/W#
cfg_load_i  in  1  loads the cfg_* values into the internal count registers
cfg_addr_count_i  in  CNT_W  address sample count within Phi1
cfg_data_count_i  in  CNT_W  first data tap count within Phi0
addr_o  out  ADDR_W  latched address
rw_n_o  out  1  latched R/W#
data_o  out  DATA_W  last voted write data
data_in_strobe_o  out  1  one-clock pulse when data_o is valid for the current cycle
phi0_o  out  1  synchronised Phi0 (inverse of synced Phi1)
cycle_valid_o  out  1  FIFO non-empty
cycle_ready_i  in  1  consumer pop
cycle_addr_o  out  ADDR_W  head record address
cycle_data_o  out  DATA_W  head record voted data
cycle_rw_n_o  out  1  head record R/W#
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  record count
overflow_o  out  1  sticky drop flag
clear_overflow_i  in  1  clears overflow_o
sleep_o  out  1  counter saturated (no Phi edge for 2^CNT_W-1 clocks)

Behaviour:
- Reset (async, any time, including mid-cycle or mid-FIFO):
  - sync chain, cnt, addr_o, data_o, cycle_* data, fifo_level_o, strobe, overflow and addr_valid all go to 0.
  - rw_n_o and cycle_rw_n_o go to 1.
  - Count registers go to ADDR_COUNT/DATA_COUNT.
  - sleep_o deasserts.
- Synchronisation: phi1_s is the last of SYNC_STAGES flops. An edge is phi1_s ≠ its previous value. phi0_o = ~phi1_s.
- Phase counter:
  - On an edge, cnt ← 0.
  - Otherwise cnt increments and saturates at all-ones.
  - sleep_o = (cnt == all-ones).
- Address capture: when phi1_s && cnt == addr_count && !sleep_o, latch addr_o and rw_n_o, and set addr_valid.
- Data taps:
  - Tap k fires when !phi1_s && cnt == data_count + k*TAP_SPACING.
  - The sum is computed in CNT_W+1 bits; a tap whose count ≥ 2^CNT_W-1 never fires.
  - Each tap stores a_d_i into tap register k.
- Completion: on the clock after the last tap, compute the voted value, where bit i = majority of the taps' bit i.
  - data_in_strobe_o pulses high for 1 clock.
  - data_o ← voted value only if rw_n_o == 0; otherwise data_o holds.
- Abort: if a Phi edge occurs before the last tap fires, the partial taps are discarded and there is no strobe and no push.
- FIFO push:
  - Occurs on the strobe clock if addr_valid; record = {addr_o, voted data, rw_n_o}, and addr_valid clears.
  - If there was no address capture since the last push, there is no push.
- FIFO pop: occurs when cycle_valid_o && cycle_ready_i; head advances next clock. Show-ahead: the cycle_* outputs always reflect the head entry.
- Full:
  - A push while full is accepted only if a pop occurs in the same clock (level unchanged).
  - Otherwise the record is dropped and overflow_o ← 1.
- Empty: a pop is ignored. A simultaneous push+pop on empty makes the pushed record visible next clock, with level = 1.
- overflow_o:
  - Stays set until clear_overflow_i.
  - If a new drop coincides with clear_overflow_i, the flag stays set.
- Config:
  - cfg_load_i latches the counts at the end of the current clock.
  - A change mid-phase applies to the next comparisons; taps not yet fired use the new data_count.
- Pointers wrap modulo FIFO_DEPTH; the level is never more than FIFO_DEPTH.
- Latency: Phi edge → cnt clear is SYNC_STAGES+1 clocks.

Test Plan:
- Defaults; Phi1 26 clk high / 26 low, a2_a_i=C0E9, rw_n=0, a2_d_i=5A stable → addr_o=C0E9; strobe at Phi0 cnt 18; data_o=5A; FIFO record {C0E9,5A,0}; level=1.
- DATA_TAPS=3, spacing 1; data=5A except FF on tap 1 only → voted 5A; data_o=5A.
- Read cycle rw_n=1, data=A5, prior data_o=5A → strobe fires; data_o stays 5A; FIFO data=A5, rw_n=1.
- cycle_ready_i=0 for 9 bus cycles, depth 8 → level=8, overflow_o=1 after the 9th; then pop+push in the same clock at full → level stays 8; clear_overflow_i → 0.
- Phi1 held low for 80 clocks → sleep_o=1 at cnt=63, no extra strobes; cfg_data_count_i=30 loaded, 26-clock Phi0 → no strobe, no push.
- Assert reset at cnt=16 of Phi0 with level=3 → all outputs return to reset values immediately; no strobe after release.

Source files
------------

// File: rtl/apple_bus_sampler.sv
// Apple II bus sampler: syncs Phi1, captures addr/RW and majority-voted data at programmable counts.
// Latency: Phi edge to counter clear is SYNC_STAGES+1 clocks; strobe one clock after the last data tap.
// Backpressure: show-ahead record FIFO popped by cycle_ready_i; a push into a full FIFO is dropped (sticky overflow).
module apple_bus_sampler #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 6,
  parameter int ADDR_COUNT  = 18,
  parameter int DATA_COUNT  = 15,
  parameter int DATA_TAPS   = 3,
  parameter int TAP_SPACING = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_logic_i,
  input  logic                          system_reset_n_i,
  input  logic                          phi1_i,
  input  logic [ADDR_W-1:0]             a2_a_i,
  input  logic [DATA_W-1:0]             a2_d_i,
  input  logic                          a2_rw_n_i,
  input  logic                          cfg_load_i,
  input  logic [CNT_W-1:0]              cfg_addr_count_i,
  input  logic [CNT_W-1:0]              cfg_data_count_i,
  output logic [ADDR_W-1:0]             addr_o,
  output logic                          rw_n_o,
  output logic [DATA_W-1:0]             data_o,
  output logic                          data_in_strobe_o,
  output logic                          phi0_o,
  output logic                          cycle_valid_o,
  input  logic                          cycle_ready_i,
  output logic [ADDR_W-1:0]             cycle_addr_o,
  output logic [DATA_W-1:0]             cycle_data_o,
  output logic                          cycle_rw_n_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          clear_overflow_i,
  output logic                          sleep_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = ADDR_W + DATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W:0]   TAP_LIMIT = {1'b0, CNT_SAT};
  localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   phi1_s, phi1_prev_q, phi_edge, phase_ok_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       addr_cnt_q, data_cnt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   rw_n_q, addr_valid_q, addr_hit;
  logic [DATA_W-1:0]      tap_q [DATA_TAPS];
  logic [CNT_W:0]         tap_cnt [DATA_TAPS];
  logic [DATA_TAPS-1:0]   tap_fire;
  logic                   strobe_q;
  logic [DATA_W-1:0]      data_q, voted;
  int                     ones;
  logic [REC_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         level_q;
  logic                   overflow_q, push_req, push, pop, full, drop;

  assign phi1_s   = sync_q[SYNC_STAGES-1];
  assign phi_edge = phi1_s != phi1_prev_q;
  assign phi0_o   = ~phi1_s;
  assign sleep_o  = cnt_q == CNT_SAT;

  // Phi1 synchroniser, edge history, and phase-alignment flag (counts mean nothing until an edge is seen)
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      sync_q      <= '0;
      phi1_prev_q <= 1'b0;
      phase_ok_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], phi1_i};
      phi1_prev_q <= phi1_s;
      if (phi_edge) phase_ok_q <= 1'b1;
    end
  end

  // Phase counter: clear on edge, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (phi_edge)             cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
  end

  // Counter and runtime sample-point registers
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      cnt_q      <= '0;
      addr_cnt_q <= CNT_W'(ADDR_COUNT);
      data_cnt_q <= CNT_W'(DATA_COUNT);
    end else begin
      cnt_q <= cnt_d;
      if (cfg_load_i) begin
        addr_cnt_q <= cfg_addr_count_i;
        data_cnt_q <= cfg_data_count_i;
      end
    end
  end

  // Tap k fires at data_count + k*spacing in Phi0; sums reaching the saturation value never fire
  always_comb begin
    for (int k = 0; k < DATA_TAPS; k++) begin
      tap_cnt[k]  = {1'b0, data_cnt_q} + (CNT_W+1)'(k * TAP_SPACING);
      tap_fire[k] = phase_ok_q && !phi1_s && (tap_cnt[k] < TAP_LIMIT) &&
                    (cnt_q == tap_cnt[k][CNT_W-1:0]);
    end
  end

  assign addr_hit = phase_ok_q && phi1_s && (cnt_q == addr_cnt_q) && !sleep_o;

  // Bitwise majority across the tap registers
  always_comb begin
    voted = '0;
    ones  = 0;
    for (int b = 0; b < DATA_W; b++) begin
      ones = 0;
      for (int k = 0; k < DATA_TAPS; k++) ones = ones + int'(tap_q[k][b]);
      voted[b] = ones > (DATA_TAPS / 2);
    end
  end

  // Address/RW capture, tap storage, completion strobe and write-data latch
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      addr_q       <= '0;
      rw_n_q       <= 1'b1;
      addr_valid_q <= 1'b0;
      strobe_q     <= 1'b0;
      data_q       <= '0;
      for (int k = 0; k < DATA_TAPS; k++) tap_q[k] <= '0;
    end else begin
      if (addr_hit) begin
        addr_q       <= a2_a_i;
        rw_n_q       <= a2_rw_n_i;
        addr_valid_q <= 1'b1;
      end else if (strobe_q) begin
        addr_valid_q <= 1'b0;
      end
      for (int k = 0; k < DATA_TAPS; k++) if (tap_fire[k]) tap_q[k] <= a2_d_i;
      strobe_q <= tap_fire[DATA_TAPS-1];
      if (strobe_q && !rw_n_q) data_q <= voted;
    end
  end

  assign push_req = strobe_q && addr_valid_q;
  assign full     = level_q == LVL_FULL;
  assign pop      = (level_q != '0) && cycle_ready_i;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Record FIFO: full+pop frees the head slot, which the incoming record then takes as tail
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {{(ADDR_W+DATA_W){1'b0}}, 1'b1};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {addr_q, voted, rw_n_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop)                  overflow_q <= 1'b1;
      else if (clear_overflow_i) overflow_q <= 1'b0;
    end
  end

  assign addr_o           = addr_q;
  assign rw_n_o           = rw_n_q;
  assign data_o           = data_q;
  assign data_in_strobe_o = strobe_q;
  assign cycle_valid_o    = level_q != '0;
  assign {cycle_addr_o, cycle_data_o, cycle_rw_n_o} = mem_q[rd_ptr_q];
  assign fifo_level_o     = level_q;
  assign overflow_o       = overflow_q;

endmodule
